// File: rtl/ifetch_line_buffer_if.sv
// Line-fill memory port of the instruction fetch buffer: request handshake plus burst response.
interface ifetch_line_buffer_if;
    logic        MemReqValid;
    logic [31:0] MemReqAddr;
    logic        MemReqReady;
    logic        MemRespValid;
    logic [31:0] MemRespData;

    modport master (
        output MemReqValid,
        output MemReqAddr,
        input  MemReqReady,
        input  MemRespValid,
        input  MemRespData
    );

    modport slave (
        input  MemReqValid,
        input  MemReqAddr,
        output MemReqReady,
        output MemRespValid,
        output MemRespData
    );
endinterface

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer; stalls the IF stage and refills a whole line on a miss.
// Optional feature macro IFETCH_CRITICAL_WORD_EN: hits on already-arrived words while a fill streams in.
module ifetch_line_buffer #(
    parameter int LINE_WORDS = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [31:0]                 PC,
    input  logic                        Invalidate,
    output logic [31:0]                 Instr,
    output logic                        Stall,
    ifetch_line_buffer_if.master        mem
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - OFF_W;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t                 state_reg;
    logic                   line_valid_reg;
    logic                   poison_reg;
    logic                   req_valid_reg;
    logic [TAG_W-1:0]       tag_reg;
    logic [LINE_WORDS-1:0]  word_valid_reg;
    logic [OFF_W-1:0]       count_reg;
    logic [31:0]            req_addr_reg;
    logic [31:0]            data_reg [LINE_WORDS];

    logic [TAG_W-1:0]       pc_tag;
    logic [OFF_W-1:0]       pc_off;
    logic                   tag_match;
    logic                   hit;
    logic                   resp_fire;
    logic                   unused_pc_bits;

    assign pc_tag         = PC[31:OFF_W+2];
    assign pc_off         = PC[OFF_W+1:2];
    assign unused_pc_bits = &{1'b0, PC[1:0]};
    assign tag_match      = (tag_reg == pc_tag);

`ifdef IFETCH_CRITICAL_WORD_EN
    // During an unpoisoned fill, individual arrived words are already usable.
    assign hit = tag_match & word_valid_reg[pc_off] &
                 (line_valid_reg | ((state_reg == FILL) & ~poison_reg));
`else
    assign hit = line_valid_reg & tag_match & word_valid_reg[pc_off];
`endif

    assign Stall           = ~hit;
    assign Instr           = data_reg[pc_off];
    assign mem.MemReqValid = req_valid_reg;
    assign mem.MemReqAddr  = req_addr_reg;
    assign resp_fire       = (state_reg == FILL) & mem.MemRespValid;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_reg[i] <= '0;
            end
        end else if (resp_fire) begin
            data_reg[count_reg] <= mem.MemRespData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            line_valid_reg <= 1'b0;
            word_valid_reg <= '0;
            poison_reg     <= 1'b0;
            count_reg      <= '0;
            req_valid_reg  <= 1'b0;
            req_addr_reg   <= '0;
            tag_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Invalidate) begin
                        line_valid_reg <= 1'b0;
                        word_valid_reg <= '0;
                    end
                    if (!hit) begin
                        req_addr_reg   <= {pc_tag, {(OFF_W + 2){1'b0}}};
                        tag_reg        <= pc_tag;
                        line_valid_reg <= 1'b0;
                        word_valid_reg <= '0;
                        count_reg      <= '0;
                        req_valid_reg  <= 1'b1;
                        state_reg      <= REQ;
                    end
                end
                REQ: begin
                    if (Invalidate) begin
                        poison_reg <= 1'b1;
                    end
                    if (mem.MemReqReady) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= FILL;
                    end
                end
                FILL: begin
                    if (Invalidate) begin
                        poison_reg <= 1'b1;
                    end
                    if (mem.MemRespValid) begin
                        word_valid_reg[count_reg] <= 1'b1;
                        count_reg                 <= count_reg + OFF_W'(1);
                        if (count_reg == LAST_OFF) begin
                            // Later assignments override the per-word set and poison set above.
                            state_reg  <= IDLE;
                            poison_reg <= 1'b0;
                            if (poison_reg || Invalidate) begin
                                line_valid_reg <= 1'b0;
                                word_valid_reg <= '0;
                            end else begin
                                line_valid_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Self-checking bench for ifetch_line_buffer: directed scenarios plus a randomized fetch stream
// checked against a "last completed clean line" reference model.
module tb_ifetch_line_buffer;
    localparam int LW = 4;
`ifdef IFETCH_CRITICAL_WORD_EN
    localparam bit CW = 1'b1;
`else
    localparam bit CW = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PC = 32'h4000_0000;
    logic        Invalidate = 1'b0;
    logic [31:0] Instr;
    logic        Stall;

    ifetch_line_buffer_if mem ();

    ifetch_line_buffer #(.LINE_WORDS(LW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PC         (PC),
        .Invalidate (Invalidate),
        .Instr      (Instr),
        .Stall      (Stall),
        .mem        (mem)
    );

    always #5 Clk = ~Clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: the buffer holds the most recent line whose fill finished unpoisoned.
    bit          ref_valid;
    logic [31:0] ref_base;
    logic [31:0] ref_data [LW];
    logic [31:0] wbuf [LW];

    function automatic logic [31:0] line_base(input logic [31:0] pc);
        return pc & ~(32'(LW * 4) - 32'd1);
    endfunction

    function automatic int off(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(LW - 1));
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return ref_valid && (line_base(pc) == ref_base);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Invalidate       = 1'b0;
        mem.MemReqReady  = 1'b0;
        mem.MemRespValid = 1'b0;
        mem.MemRespData  = $urandom;
    endtask

    task automatic rand_words();
        for (int i = 0; i < LW; i++) wbuf[i] = $urandom;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        chk1("rst_req_valid", mem.MemReqValid, 1'b0);
        chk("rst_req_addr", mem.MemReqAddr, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk1("rst_stall", Stall, 1'b1);
        Reset = 1'b0;
        ref_valid = 1'b0;
        $display("reset");
    endtask

    task automatic fetch_hit(input logic [31:0] pc);
        idle_inputs();
        PC = pc;
        #1;
        chk1("hit_stall", Stall, 1'b0);
        chk("hit_instr", Instr, ref_data[off(pc)]);
        chk1("hit_noreq", mem.MemReqValid, 1'b0);
        $display("hit  pc=%h instr=%h", pc, Instr);
        @(negedge Clk);
    endtask

    task automatic inval_idle(input logic [31:0] pc);
        idle_inputs();
        PC = pc;
        Invalidate = 1'b1;
        #1;
        chk1("inv_idle_stall", Stall, 1'b0);
        @(negedge Clk);
        ref_valid = 1'b0;
        $display("invalidate in idle pc=%h", pc);
    endtask

    // Full miss sequence; ends after the post-fill check without consuming that cycle.
    task automatic do_miss(input logic [31:0] pc, input int req_wait, input bit inv_on_miss,
                           input int inv_at, input bit gaps, input bit junk);
        logic [31:0] base;
        int          o;
        int          arrived;
        bit          poisoned;
        logic        exp_s;
        base = line_base(pc);
        o = off(pc);
        arrived = 0;
        poisoned = 1'b0;
        idle_inputs();
        PC = pc;
        Invalidate = inv_on_miss;
        #1;
        chk1("miss_stall", Stall, 1'b1);
        chk1("miss_noreq", mem.MemReqValid, 1'b0);
        @(negedge Clk);
        for (int d = 0; d <= req_wait; d++) begin
            idle_inputs();
            mem.MemReqReady = (d == req_wait);
            if (junk) mem.MemRespValid = 1'($urandom_range(0, 1));
            #1;
            chk1("req_valid", mem.MemReqValid, 1'b1);
            chk("req_addr", mem.MemReqAddr, base);
            chk1("req_stall", Stall, 1'b1);
            @(negedge Clk);
        end
        for (int w = 0; w < LW; w++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    idle_inputs();
                    #1;
                    exp_s = !(CW && arrived > o && !poisoned);
                    chk1("gap_stall", Stall, exp_s);
                    chk1("gap_noreq", mem.MemReqValid, 1'b0);
                    @(negedge Clk);
                end
            end
            idle_inputs();
            mem.MemRespValid = 1'b1;
            mem.MemRespData  = wbuf[w];
            Invalidate = (w == inv_at);
            #1;
            exp_s = !(CW && arrived > o && !poisoned);
            chk1("fill_stall", Stall, exp_s);
            if (!exp_s) chk("fill_instr", Instr, wbuf[o]);
            chk1("fill_noreq", mem.MemReqValid, 1'b0);
            @(negedge Clk);
            if (w == inv_at) poisoned = 1'b1;
            arrived++;
        end
        if (inv_at < 0) begin
            ref_valid = 1'b1;
            ref_base = base;
            for (int i = 0; i < LW; i++) ref_data[i] = wbuf[i];
        end else begin
            ref_valid = 1'b0;
        end
        $display("fill base=%h wait=%0d inv_at=%0d words=%h %h %h %h",
                 base, req_wait, inv_at, wbuf[0], wbuf[1], wbuf[2], wbuf[3]);
        idle_inputs();
        #1;
        exp_s = !model_hit(pc);
        chk1("post_stall", Stall, exp_s);
        if (!exp_s) chk("post_instr", Instr, ref_data[o]);
        chk1("post_noreq", mem.MemReqValid, 1'b0);
    endtask

    task automatic partial_fill(input logic [31:0] pc, input int n);
        idle_inputs();
        PC = pc;
        #1;
        chk1("pf_miss_stall", Stall, 1'b1);
        @(negedge Clk);
        idle_inputs();
        mem.MemReqReady = 1'b1;
        #1;
        chk1("pf_req_valid", mem.MemReqValid, 1'b1);
        @(negedge Clk);
        for (int w = 0; w < n; w++) begin
            idle_inputs();
            mem.MemRespValid = 1'b1;
            mem.MemRespData  = $urandom;
            @(negedge Clk);
        end
        $display("partial fill pc=%h words=%0d", pc, n);
    endtask

    // Critical-word scenario: PC advances to offset 1 while word 1 is still arriving.
    task automatic cw_scenario();
        logic [31:0] base;
        base = 32'h4000_0020;
        rand_words();
        idle_inputs();
        PC = base;
        #1;
        chk1("cw_miss_stall", Stall, 1'b1);
        @(negedge Clk);
        idle_inputs();
        mem.MemReqReady = 1'b1;
        #1;
        chk("cw_req_addr", mem.MemReqAddr, base);
        @(negedge Clk);
        idle_inputs();
        mem.MemRespValid = 1'b1;
        mem.MemRespData  = wbuf[0];
        #1;
        chk1("cw_k_stall", Stall, 1'b1);
        @(negedge Clk);
        idle_inputs();
        mem.MemRespValid = 1'b1;
        mem.MemRespData  = wbuf[1];
        #1;
        chk1("cw_k1_off0_stall", Stall, !CW);
        if (CW) chk("cw_k1_off0_instr", Instr, wbuf[0]);
        PC = base + 32'd4;
        #1;
        chk1("cw_k1_off1_stall", Stall, 1'b1);
        @(negedge Clk);
        for (int w = 2; w < LW; w++) begin
            idle_inputs();
            mem.MemRespValid = 1'b1;
            mem.MemRespData  = wbuf[w];
            #1;
            chk1("cw_stream_stall", Stall, !CW);
            if (CW) chk("cw_stream_instr", Instr, wbuf[1]);
            @(negedge Clk);
        end
        ref_valid = 1'b1;
        ref_base = base;
        for (int i = 0; i < LW; i++) ref_data[i] = wbuf[i];
        idle_inputs();
        #1;
        chk1("cw_done_stall", Stall, 1'b0);
        chk("cw_done_instr", Instr, wbuf[1]);
        $display("critical-word fill base=%h cw=%0d", base, CW);
        @(negedge Clk);
    endtask

    initial begin
        logic [31:0] pc;
        idle_inputs();
        ref_valid = 1'b0;
        for (int i = 0; i < LW; i++) ref_data[i] = '0;

        // Cold start
        PC = 32'h4000_0000;
        do_reset();
        for (int i = 0; i < LW; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_miss(32'h4000_0000, 0, 1'b0, -1, 1'b0, 1'b0);

        // Sequential hits
        fetch_hit(32'h4000_0004);
        fetch_hit(32'h4000_0008);
        fetch_hit(32'h4000_000C);

        // Line crossing with request backpressure, then the old line must miss
        rand_words();
        do_miss(32'h4000_0010, 3, 1'b0, -1, 1'b0, 1'b1);
        fetch_hit(32'h4000_0014);
        rand_words();
        do_miss(32'h4000_0008, 1, 1'b0, -1, 1'b1, 1'b0);

        // Invalidate during the 2nd response, then a second request to the same line
        rand_words();
        do_miss(32'h4000_0030, 0, 1'b0, 1, 1'b0, 1'b0);
        rand_words();
        do_miss(32'h4000_0030, 0, 1'b0, -1, 1'b0, 1'b0);

        // Invalidate on the last response
        rand_words();
        do_miss(32'h4000_0044, 1, 1'b0, LW - 1, 1'b1, 1'b1);
        rand_words();
        do_miss(32'h4000_0044, 0, 1'b0, -1, 1'b0, 1'b0);

        // Invalidate in the same cycle as an IDLE miss
        rand_words();
        do_miss(32'h4000_0058, 0, 1'b1, -1, 1'b0, 1'b0);

        // Invalidate while idle on a valid line
        inval_idle(32'h4000_0058);
        rand_words();
        do_miss(32'h4000_0058, 0, 1'b0, -1, 1'b0, 1'b0);

        // Reset mid-fill, then a clean refill
        partial_fill(32'h4000_0060, 2);
        do_reset();
        rand_words();
        do_miss(32'h4000_0060, 0, 1'b0, -1, 1'b0, 1'b0);

        cw_scenario();

        // Randomized fetch stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                pc = $urandom;
            else
                pc = 32'h4000_0000 + 32'($urandom_range(0, 3) * 16)
                     + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            if (model_hit(pc)) begin
                if ($urandom_range(0, 9) == 0) inval_idle(pc);
                else fetch_hit(pc);
            end else begin
                rand_words();
                do_miss(pc, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 5) == 0) ? $urandom_range(0, LW - 1) : -1,
                        1'b1, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ifetch_line_buffer.md
# ifetch_line_buffer

Single-line instruction fetch buffer between the IF-stage PC register and the instruction memory port. It takes the current fetch PC and returns the instruction word. On a line miss it holds the IF stage with `Stall` and refills a whole line from memory over a request/burst-response handshake. `Stall` feeds the PC register's stall input directly, so a held PC stays constant while a miss is serviced.

## Interface
- `LINE_WORDS`, 4: words per line; power of two, ≥2.
- `OFF_W`, log2(`LINE_WORDS`): word-offset width; derived, do not override.

- `Clk` in 1: clock.
- `Reset` in 1: reset, synchronous, active-high.
- `PC` in 32: fetch address from the PC register. Bits [1:0] are ignored.
- `Invalidate` in 1: one-cycle pulse that discards buffer contents.
- `Instr` out 32: instruction at `PC`; meaningful only when `Stall`=0.
- `Stall` out 1: combinational; 1 = instruction not yet available, hold PC.
- `MemReqValid` out 1: line-fill request valid.
- `MemReqAddr` out 32: line base address, with bits [OFF_W+1:0] = 0.
- `MemReqReady` in 1: memory accepts the request.
- `MemRespValid` in 1: one response word present.
- `MemRespData` in 32: response word. Words arrive in ascending offset order, `LINE_WORDS` per request.

## Operation
- Storage:
  - `LineValid`: 1 bit.
  - `Tag`: PC[31:OFF_W+2].
  - `WordValid`: `LINE_WORDS` bits.
  - Data: `LINE_WORDS`×32.
- Hit: `LineValid` & tag match & `WordValid[PC[OFF_W+1:2]]`.
  - On a hit, `Stall`=0 and `Instr` = data[offset], combinational from registered storage.
- FSM states: IDLE, REQ, FILL.
  - IDLE: on a miss, latch the line base address from PC, clear `LineValid`, `WordValid` and the fill counter, load `Tag`, then go to REQ.
  - REQ: `MemReqValid`=1 and `MemReqAddr` = latched base. `MemReqAddr` holds until `MemReqReady`=1, then go to FILL.
  - FILL: each `MemRespValid` writes data[count] and sets `WordValid[count]`, then increments count. On the response with count = `LINE_WORDS`-1, set `LineValid` (unless poisoned) and go to IDLE.
  - `MemRespValid` outside FILL is ignored.
- `Stall` = ~hit in every state.
  - A miss to a different line while in REQ or FILL keeps `Stall`=1. The current fill completes first, then IDLE issues the new miss.
- `Invalidate`:
  - In IDLE: clears `LineValid` and `WordValid`.
  - In REQ or FILL: sets a poison flag. The fill completes, but `LineValid` and `WordValid` end at 0. Poison is cleared on entry to IDLE.
- `Reset` has priority over everything:
  - state = IDLE; `LineValid`, `WordValid`, poison and count = 0.
  - `MemReqValid` = 0; `MemReqAddr` = 0; data regs = 0, so `Instr` = 0.
  - `Stall` after reset is 1, because nothing is valid.
  - Reset mid-fill abandons the burst. The memory is reset by the same `Reset`, so no stale responses arrive.
- Offset arithmetic wraps modulo `LINE_WORDS`. The tag compare is a full-width compare of PC[31:OFF_W+2].

## Timing
- Hit: zero latency; `Instr` is valid in the same cycle as `PC`.
- Miss detected in IDLE at cycle N:
  - `MemReqValid`=1 from N+1.
  - If `MemReqReady`=1 at N+1, FILL is entered at N+2.
  - The earliest first response is at N+2.
- Last response at cycle M: `LineValid`=1 and `Stall`=0 at M+1.
  - Minimum miss penalty is `LINE_WORDS`+2 cycles.
- `MemReqValid` is registered, asserted exactly while in REQ, and never drops before `MemReqReady`.
- Simultaneous events:
  - `Invalidate` on the same cycle as the last response: poison wins, so the line ends invalid.
  - `Invalidate` on the same cycle as an IDLE miss: the miss proceeds and the new fill is not poisoned.

## Configuration
- `IFETCH_CRITICAL_WORD_EN`:
  - Defined: during FILL the hit test uses `WordValid`. A word written at cycle k is hit-able at k+1, so PC may advance through already-arrived words while the rest of the line streams in. `LineValid` is set at the end of the fill as before.
  - Not defined: the hit test requires `LineValid`. `Stall` stays 1 for any PC until the whole line is written.

## Test plan
- Cold start, `LINE_WORDS`=4:
  - Stimulus: release `Reset` with PC=0x40000000; `MemReqReady`=1; respond 0xA0..0xA3 back-to-back.
  - Required: `MemReqValid` one cycle with addr 0x40000000; `Stall`=0 and `Instr`=0xA0 the cycle after the last word.
- Sequential hits:
  - Stimulus: after the cold start, PC steps 0x40000004, 0x40000008, 0x4000000C.
  - Required: `Stall`=0 throughout; `Instr` = 0xA1, 0xA2, 0xA3; no `MemReqValid`.
- Line crossing and backpressure:
  - Stimulus: PC=0x40000010; `MemReqReady` held 0 for 3 cycles.
  - Required: `MemReqAddr`=0x40000010 stable for 4 cycles; fill completes; `Tag` updated.
- Invalidate mid-fill:
  - Stimulus: pulse `Invalidate` during the 2nd response.
  - Required: fill completes; `Stall` stays 1; a second request to the same address follows.
- Reset mid-fill:
  - Stimulus: assert `Reset` after 2 responses.
  - Required: next cycle `MemReqValid`=0, `Stall`=1, `Instr`=0; a clean refill follows.
- With `IFETCH_CRITICAL_WORD_EN`:
  - Stimulus: miss at 0x40000020; word 0 arrives at cycle k; PC=0x40000024 requested at k+1 while word 1 arrives at k+1.
  - Required: `Stall`=0 at k+1 for offset 0; `Stall`=0 at k+2 for offset 1. Without the macro, `Stall`=1 until after word 3.
